// File: rtl/mem_if_pkg.sv
// Shared types and widths for the data-memory request master.
// Optional build macro used by mem_req_master: MISALIGN_CHECK_EN.
package mem_if_pkg;

    localparam int WORD_W    = 16;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter that times how long the memory pins are held in ACCESS.
// zero_o marks the final hold cycle; the count saturates at zero.
module mem_lat_counter
    import mem_if_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [LAT_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous reset, so every flop updates together on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_req_master.sv
// Load/store initiator for the single-cycle data memory: one access at a time.
// Define MISALIGN_CHECK_EN to reject odd addresses with rsp_err instead of aligning them.
module mem_req_master
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY);

    mem_state_t            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic                  req_fire;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
`ifdef MISALIGN_CHECK_EN
    logic                  err_q, err_d;
`endif

    assign req_fire = req_valid && req_ready;

    mem_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef MISALIGN_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr & ~ADDR_WIDTH'(1);
                    wdata_d = req_wdata;
                    rdata_d = '0;
`ifdef MISALIGN_CHECK_EN
                    err_d   = req_addr[0];
                    if (req_addr[0]) begin
                        state_d = RESP;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ACCESS;
                    end
`else
                    cnt_load = 1'b1;
                    state_d  = ACCESS;
`endif
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    // Stores report zero data; loads capture the memory output.
                    rdata_d = wr_q ? '0 : mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs are gated by rst so a mid-operation reset silences the pins in the same cycle.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign mem_enable = (state_q == ACCESS) && !rst;
    assign mem_wr     = mem_enable && wr_q;
    assign mem_addr   = mem_enable ? addr_q : '0;
    assign mem_wdata  = mem_enable ? wdata_q : '0;
    assign rsp_valid  = (state_q == RESP) && !rst;
    assign rsp_rdata  = rsp_valid ? rdata_q : '0;
`ifdef MISALIGN_CHECK_EN
    assign rsp_err    = rsp_valid && err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: two instances (zero and three cycles of extra hold),
// each driving its own small behavioural data memory.
`timescale 1ns/1ps
module tb_mem_req_master;

    localparam int LAT_A = 0;
    localparam int LAT_B = 3;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_wr;
    logic [15:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [15:0] a_rsp_rdata;
    logic        a_mem_enable, a_mem_wr;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_req_valid, b_req_ready, b_req_wr;
    logic [15:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [15:0] b_rsp_rdata;
    logic        b_mem_enable, b_mem_wr;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [15:0] mem_a   [0:255];
    logic [15:0] mem_b   [0:255];
    logic [15:0] ref_mem [0:255];

    int n_vec = 0;
    int n_bad = 0;

    mem_req_master #(.ADDR_WIDTH(16), .MEM_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_enable(a_mem_enable), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_req_master #(.ADDR_WIDTH(16), .MEM_LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_enable(b_mem_enable), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [15:0] init_word(input int i);
        return (i == 16) ? 16'h1234 : (16'(i * 257) ^ 16'hC3C3);
    endfunction

    // Single-cycle memories: combinational read, write on the edge unless in reset.
    assign a_mem_rdata = mem_a[a_mem_addr[8:1]];
    assign b_mem_rdata = mem_b[b_mem_addr[8:1]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
        end else if (!rst && a_mem_enable && a_mem_wr) begin
            mem_a[a_mem_addr[8:1]] <= a_mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
        end else if (!rst && b_mem_enable && b_mem_wr) begin
            mem_b[b_mem_addr[8:1]] <= b_mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: what a request should produce for the LAT_A instance, judged from the
    // memory contents the requests so far should have left behind.
    task automatic model_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rdata, output logic err,
                             output int lat, output int en_cycles);
        int idx;
        idx = int'(addr[8:1]);
`ifdef MISALIGN_CHECK_EN
        if (addr[0]) begin
            rdata = 16'h0; err = 1'b1; lat = 1; en_cycles = 0;
            return;
        end
`endif
        err       = 1'b0;
        lat       = LAT_A + 2;
        en_cycles = LAT_A + 1;
        if (wr) begin
            ref_mem[idx] = wdata;
            rdata        = 16'h0;
        end else begin
            rdata = ref_mem[idx];
        end
    endtask

    // One full request/response on instance A; entered and left #1 after a posedge.
    task automatic run_txn(input string name, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int rdy_delay,
                           output logic [15:0] got_rdata, output logic got_err);
        logic [15:0] exp_rdata;
        logic        exp_err;
        int exp_lat, exp_en;
        int waited, lat, en_cyc, wr_cyc, pin_bad, hold_bad;
        waited = 0; en_cyc = 0; wr_cyc = 0; pin_bad = 0; hold_bad = 0;
        model_txn(wr, addr, wdata, exp_rdata, exp_err, exp_lat, exp_en);
        a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_wdata = wdata;
        while (!a_req_ready && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        check({name, "/req_ready"}, 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 40) begin
            if (a_mem_enable) begin
                en_cyc++;
                if (a_mem_addr !== {addr[15:1], 1'b0}) pin_bad++;
                if (wr && (a_mem_wdata !== wdata)) pin_bad++;
            end
            if (a_mem_wr) wr_cyc++;
            @(posedge clk); #1; lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'(exp_lat));
        check({name, "/enable_cycles"}, 32'(en_cyc), 32'(exp_en));
        check({name, "/wr_cycles"}, 32'(wr_cyc), wr ? 32'(exp_en) : 32'd0);
        check({name, "/pins"}, 32'(pin_bad), 32'd0);
        got_rdata = a_rsp_rdata;
        got_err   = a_rsp_err;
        check({name, "/rdata"}, 32'(got_rdata), 32'(exp_rdata));
        check({name, "/err"}, 32'(got_err), 32'(exp_err));
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge clk); #1;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== got_rdata) hold_bad++;
        end
        check({name, "/rsp_hold"}, 32'(hold_bad), 32'd0);
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        check({name, "/rsp_drop"}, 32'(a_rsp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [6];
        logic [15:0] r;
        logic        e;
        logic [15:0] exp_r;
        logic        exp_e;
        int          lat, en, dummy_lat, dummy_en;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0012, 16'h0F0F, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 16'h0012, 16'h0000, 16'h0F0F, 1'b0};
        vecs[4] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
`ifdef MISALIGN_CHECK_EN
        vecs[5] = '{1'b0, 16'h0031, 16'h0000, 16'h0000, 1'b1};
`else
        vecs[5] = '{1'b0, 16'h0031, 16'h0000, init_word(24), 1'b0};
`endif

        // Reset: hold three cycles with a request pending; it must be ignored.
        rst = 1'b1; preload = 1'b1;
        a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 16'h0002; a_req_wdata = 16'hDEAD;
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 16'h0; b_req_wdata = 16'h0;
        b_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            preload = 1'b0;
            check("reset/mem_enable", 32'(a_mem_enable), 32'd0);
            check("reset/mem_wr", 32'(a_mem_wr), 32'd0);
            check("reset/rsp_valid", 32'(a_rsp_valid), 32'd0);
            check("reset/req_ready", 32'(a_req_ready), 32'd0);
        end
        a_req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("reset/req_ready_after", 32'(a_req_ready), 32'd1);
        check("reset/rsp_valid_after", 32'(a_rsp_valid), 32'd0);

        // Directed table: store/load pairs and the odd-address case.
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, r, e);
            check($sformatf("vec%0d/table_rdata", i), 32'(r), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d/table_err", i), 32'(e), 32'(vecs[i].exp_err));
        end

        // Three extra hold cycles on instance B: load of the preloaded word at 0x0020.
        b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 16'h0020;
        check("lat3/req_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat = 1; en = 0;
        while (!b_rsp_valid && lat < 40) begin
            if (b_mem_enable) en++;
            @(posedge clk); #1; lat++;
        end
        check("lat3/latency", 32'(lat), 32'(LAT_B + 2));
        check("lat3/enable_cycles", 32'(en), 32'(LAT_B + 1));
        check("lat3/rdata", 32'(b_rsp_rdata), 32'h1234);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;

        // Backpressure: response held ten cycles while a new request waits.
        model_txn(1'b0, 16'h0010, 16'h0, exp_r, exp_e, dummy_lat, dummy_en);
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 16'h0010;
        @(posedge clk); #1;
        a_req_wr = 1'b1; a_req_addr = 16'h0050; a_req_wdata = 16'h7777;
        lat = 1;
        while (!a_rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("bp/latency", 32'(lat), 32'(LAT_A + 2));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp/rsp_valid", 32'(a_rsp_valid), 32'd1);
            check("bp/rsp_rdata", 32'(a_rsp_rdata), 32'(exp_r));
            check("bp/req_ready", 32'(a_req_ready), 32'd0);
            check("bp/mem_enable", 32'(a_mem_enable), 32'd0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0; a_req_valid = 1'b0;
        check("bp/rsp_drop", 32'(a_rsp_valid), 32'd0);
        check("bp/word50_untouched", 32'(mem_a[8'h28]), 32'(init_word(40)));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic        rw;
            logic [15:0] ad, wd;
            rw = 1'($urandom_range(0, 1));
            ad = 16'($urandom_range(0, 63) * 2);
            if ($urandom_range(0, 7) == 0) ad[0] = 1'b1;
            wd = 16'($urandom);
            run_txn($sformatf("rand%0d", i), rw, ad, wd, int'($urandom_range(0, 3)), r, e);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Reset during the ACCESS cycle of a store: the store must not land.
        a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 16'h0040; a_req_wdata = 16'hAAAA;
        check("rst_mid/req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("rst_mid/in_access", 32'(a_mem_enable), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid/mem_enable", 32'(a_mem_enable), 32'd0);
        check("rst_mid/mem_wr", 32'(a_mem_wr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid/idle", 32'(a_req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_mid/no_rsp", 32'(a_rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_txn("rst_mid/readback", 1'b0, 16'h0040, 16'h0, 0, r, e);
        check("rst_mid/word40", 32'(r), 32'(init_word(32)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
